// File: rtl/gpi_pkg.sv
// gpi_pkg: register offsets, bit positions and saturating counter helper for gpi_cond
package gpi_pkg;
  localparam logic [1:0] GPI_STATUS = 2'd0;
  localparam logic [1:0] GPI_COUNT = 2'd1;
  localparam logic [1:0] GPI_CFG = 2'd2;
  localparam int LVL = 0;
  localparam int RF = 1;
  localparam int FF = 2;
  localparam int IE_R = 16;
  localparam int IE_F = 17;
  localparam int COUNT_W = 16;
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return &v ? v : v + COUNT_W'(1);
  endfunction
endpackage

// File: rtl/gpi_debounce.sv
// gpi_debounce: 2-flop synchroniser, stable-time debounce (clk_i, rst_i, pin_i, thr_i -> lvl_o, rise_o, fall_o)
module gpi_debounce #(
  parameter int DBW = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           pin_i,
  input  logic [DBW-1:0] thr_i,
  output logic           lvl_o,
  output logic           rise_o,
  output logic           fall_o
);
  logic s1, s2, lvl, lvl_d;
  logic [DBW-1:0] cnt;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      lvl <= 1'b0;
      lvl_d <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= pin_i;
      s2 <= s1;
      lvl_d <= lvl;
      cnt <= (s2 == lvl || cnt == thr_i) ? '0 : cnt + DBW'(1);
      lvl <= (s2 != lvl && cnt == thr_i) ? s2 : lvl;
    end
  end
  assign lvl_o = lvl;
  assign rise_o = lvl & ~lvl_d;
  assign fall_o = ~lvl & lvl_d;
endmodule

// File: rtl/gpi_cond.sv
// gpi_cond: Wishbone GPI conditioner; pin_i -> debounced gpi_o, STATUS/COUNT/CFG regs, irq_o only with GPI_IRQ_EN
module gpi_cond
  import gpi_pkg::*;
#(
  parameter int         DBW   = 8,
  parameter logic [7:0] DBRST = 8'd15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  output logic        ack_o,
  input  logic [1:0]  adr_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  input  logic        pin_i,
  output logic        gpi_o
`ifdef GPI_IRQ_EN
  ,
  output logic        irq_o
`endif
);
  logic lvl, rise, fall, rf, ff, ie_r, ie_f, wr, wr_st, wr_cnt, wr_cfg, unused_bits;
  logic [COUNT_W-1:0] count;
  logic [DBW-1:0] thr;
  logic [31:0] st, cf;
  gpi_debounce #(.DBW(DBW)) u_db (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .pin_i (pin_i),
    .thr_i (thr),
    .lvl_o (lvl),
    .rise_o(rise),
    .fall_o(fall)
  );
  assign ack_o = cyc_i & stb_i;
  assign wr = cyc_i & stb_i & we_i & be_i[0];
  assign wr_st = wr && adr_i == GPI_STATUS;
  assign wr_cnt = wr && adr_i == GPI_COUNT;
  assign wr_cfg = wr && adr_i == GPI_CFG;
  assign gpi_o = lvl;
  assign unused_bits = ^{dat_i, be_i[3:1]};
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rf <= 1'b0;
      ff <= 1'b0;
      count <= '0;
      thr <= DBW'(DBRST);
    end else begin
      rf <= rise | (rf & ~(wr_st & dat_i[RF]));
      ff <= fall | (ff & ~(wr_st & dat_i[FF]));
      count <= wr_cnt ? COUNT_W'(rise) : rise ? sat_inc(count) : count;
      thr <= wr_cfg ? dat_i[DBW-1:0] : thr;
    end
  end
`ifdef GPI_IRQ_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ie_r <= 1'b0;
      ie_f <= 1'b0;
    end else if (wr_cfg) begin
      ie_r <= dat_i[IE_R];
      ie_f <= dat_i[IE_F];
    end
  end
  assign irq_o = (rf & ie_r) | (ff & ie_f);
`else
  assign ie_r = 1'b0;
  assign ie_f = 1'b0;
`endif
  always_comb begin
    st = '0;
    st[LVL] = lvl;
    st[RF] = rf;
    st[FF] = ff;
    cf = '0;
    cf[DBW-1:0] = thr;
    cf[IE_R] = ie_r;
    cf[IE_F] = ie_f;
    dat_o = adr_i == GPI_STATUS ? st :
            adr_i == GPI_COUNT  ? 32'(count) :
            adr_i == GPI_CFG    ? cf : '0;
  end
endmodule

// File: doc/gpi_cond.md
# gpi_cond

Wishbone-mapped general-purpose-input conditioner sitting directly upstream of the SoC `gpio` block. It synchronises the raw asynchronous input pin, debounces it with a programmable stable-time counter, and drives the clean level to `gpio.gpi_i`. It also records rising and falling edges in sticky flags, counts rising edges, and optionally raises an interrupt.

## Interface
- `DBW`, 8: width of the debounce counter and threshold.
- `DBRST`, 8'd15: reset value of the debounce threshold; only the low `DBW` bits are used.
- `clk_i` in 1: system clock; the block has one clock.
- `rst_i` in 1: synchronous, active-high reset.
- `cyc_i` in 1: Wishbone cycle.
- `stb_i` in 1: Wishbone strobe.
- `we_i` in 1: Wishbone write enable.
- `ack_o` out 1: Wishbone acknowledge.
- `adr_i` in 2: word address; corresponds to byte address bits [3:2].
- `be_i` in 4: byte enables.
- `dat_i` in 32: write data.
- `dat_o` out 32: read data.
- `pin_i` in 1: raw asynchronous input pin.
- `gpi_o` out 1: debounced level; connects to `gpio.gpi_i`.
- `irq_o` out 1: level interrupt. Present only with `GPI_IRQ_EN`.

## Operation
- **Synchroniser.** Two flops, `s1` and `s2`, both reset to 0. `sync = s2`.
- **Debounce.** The block holds a stable level `lvl` (reset 0), a counter `cnt` (reset 0) and a threshold `thr` (reset `DBRST`).
  - If `sync == lvl`: `cnt <= 0`.
  - Otherwise, if `cnt == thr`: `lvl <= sync` and `cnt <= 0`.
  - Otherwise: `cnt <= cnt + 1`.
  - A change is accepted after `thr+1` consecutive differing cycles. `thr = 0` gives 1 cycle. `cnt` never exceeds `thr`.
- **Output.** `gpi_o = lvl`.
- **Edge detection.** Edges are detected on `lvl`. `rise` is a one-cycle pulse when `lvl` goes 0→1; `fall` is a one-cycle pulse when `lvl` goes 1→0.
- **Register map.** Word-addressed. A write is accepted when `cyc_i & stb_i & we_i & be_i[0]`; the whole register updates.
  - Word 0, STATUS:
    - bit 0: `lvl`, read-only.
    - bit 1: RF, sticky rise flag.
    - bit 2: FF, sticky fall flag.
    - Writing 1 to bit 1 or bit 2 clears that flag.
  - Word 1, COUNT:
    - bits [15:0]: rising-edge count. Saturates at 0xFFFF.
    - Any write clears the count.
  - Word 2, CFG:
    - bits [DBW-1:0]: `thr`.
    - bit 16: IE_R, rise interrupt enable.
    - bit 17: IE_F, fall interrupt enable.
    - Both enable bits reset to 0.
  - Word 3: reads 0; writes are ignored.
  - Unused bits read 0.
- **Interrupt.** `irq_o = (RF & IE_R) | (FF & IE_F)`, combinational from the registers.
- **Boundary conditions.**
  - A W1C clear in the same cycle as a new edge on that flag: the set wins and the flag stays 1.
  - A COUNT write in the same cycle as `rise`: the count becomes 1.
  - A COUNT at 0xFFFF plus `rise`: the count stays 0xFFFF.
  - A CFG write that lowers `thr` below the current `cnt`: the `cnt == thr` test cannot fire, so `cnt` keeps incrementing. It then wraps modulo 2^DBW and fires when it reaches the new `thr`. The behaviour is allowed and deterministic.
  - `rst_i` mid-debounce returns every register to its reset value. No edge is produced by reset itself.

## Timing
- **Acknowledge.** `ack_o = cyc_i & stb_i`, combinational. Every access completes in one cycle with zero wait states.
- **Read data.** `dat_o` is combinational from `adr_i` and the current register state.
- **Writes.** Writes take effect at the next rising edge of `clk_i`.
- **Pin-to-output latency.** A pin change stable from edge N appears on `gpi_o` after `2 + thr + 1` clock edges.
- **Flag and count update.** RF, FF and COUNT update on the edge after `lvl` changes, i.e. one cycle after `gpi_o`. With `GPI_IRQ_EN`, `irq_o` asserts in that same cycle.
- **Reset values.**
  - `ack_o` follows `cyc_i & stb_i` and is not registered.
  - `gpi_o` = 0.
  - `irq_o` = 0.
  - `dat_o` reads reset register contents.

## Configuration
- **`GPI_IRQ_EN` defined:**
  - `irq_o` port exists.
  - CFG bits 17:16 are implemented.
- **`GPI_IRQ_EN` undefined:**
  - No `irq_o` port.
  - CFG bits 17:16 read 0 and ignore writes.
  - Flags and COUNT still work for polling.

## Structure
- **Package `gpi_pkg`:**
  - Word offsets: `GPI_STATUS = 2'd0`, `GPI_COUNT = 2'd1`, `GPI_CFG = 2'd2`.
  - STATUS bit positions: `LVL = 0`, `RF = 1`, `FF = 2`.
  - CFG bit positions: `IE_R = 16`, `IE_F = 17`.
  - `COUNT_W = 16`.
- **Sub-module `gpi_debounce`:**
  - Contents: synchroniser, `cnt`/`lvl` logic, `rise`/`fall` pulse generation.
  - Ports: `clk_i`, `rst_i`, `pin_i`, `thr_i[DBW-1:0]`, `lvl_o`, `rise_o`, `fall_o`.
- **Top `gpi_cond`:** Wishbone decode, flags, counter, CFG register, interrupt.

## Test plan
- Reset, then read all words: STATUS = 0, COUNT = 0, CFG = `DBRST`; `gpi_o` = 0, `irq_o` = 0.
- `thr = 3`, pin 0→1 held → `gpi_o` rises exactly 6 edges after the pin change. STATUS reads 0x3. COUNT reads 1.
- `thr = 3`, pin glitches high for 3 cycles and back → `gpi_o` stays 0. RF = 0. COUNT = 0.
- CFG = 0x30000 (IE_R | IE_F), pin high then low → `irq_o` asserts after the rise. Write STATUS 0x6 → RF and FF cleared, `irq_o` = 0. Repeating with the W1C timed to coincide with a `fall` pulse leaves FF = 1.
- COUNT preloaded to 0xFFFF via 65535 rises (or forced), one more rise → COUNT stays 0xFFFF. A COUNT write coinciding with `rise` → COUNT = 1.
- Assert `rst_i` when `cnt = 2` with `thr = 5` → next cycle `cnt` = 0, `lvl` = 0, `thr` = `DBRST`, no flags set.
